multicycle_control: RTL and testbench

//  Multi-cycle RV32I main controller: the initiator side of the ALU interface. Sequences fetch/decode/execute/

---
 rtl/multicycle_control_pkg.sv | 74 +++++++
 rtl/multicycle_control_if.sv | 41 ++++
 rtl/multicycle_control_alu_decoder.sv | 44 ++++
 rtl/multicycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
//   Shared encodings for the multi-cycle RV32I main controller: ALU operation
//   codes, ALU operation classes handed to the ALU decoder, RV32I opcodes,
//   FSM state constants and the datapath mux-select encodings.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // ADD: address/PC arithmetic; FUNCT: decode from funct3/funct7;
    // BRANCH: comparison selected by the branch funct3.
    typedef enum logic [1:0] {
        CLS_ADD    = 2'd0,
        CLS_FUNCT  = 2'd1,
        CLS_BRANCH = 2'd2
    } alu_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_AUIPC    = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUREG = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALUOUT = 2'd2;
    localparam logic [1:0] RES_RSTVEC = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundle between the controller (master) and the shared datapath/memory
//   side (slave).
//   Inputs to controller : instr, isZero, aluLsb, memReady
//   Outputs of controller: memReq, memWrite, irWrite, pcWrite, branch,
//                          regWrite, adrSrc, aluSrcA, aluSrcB, immSrc,
//                          resultSrc, aluControl, illegalInstr
//   Memory handshake: memReq high means an access is pending; it completes in
//   any cycle where memReq and memReady are both high. Until then memReq,
//   adrSrc and memWrite stay stable and no write enable pulses.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        isZero;
    logic        aluLsb;
    logic        memReady;
    logic        memReq;
    logic        memWrite;
    logic        irWrite;
    logic        pcWrite;
    logic        branch;
    logic        regWrite;
    logic        adrSrc;
    logic [1:0]  aluSrcA;
    logic [1:0]  aluSrcB;
    logic [2:0]  immSrc;
    logic [1:0]  resultSrc;
    logic [3:0]  aluControl;
    logic        illegalInstr;

    modport master (
        input  instr, isZero, aluLsb, memReady,
        output memReq, memWrite, irWrite, pcWrite, branch, regWrite, adrSrc,
               aluSrcA, aluSrcB, immSrc, resultSrc, aluControl, illegalInstr
    );

    modport slave (
        output instr, isZero, aluLsb, memReady,
        input  memReq, memWrite, irWrite, pcWrite, branch, regWrite, adrSrc,
               aluSrcA, aluSrcB, immSrc, resultSrc, aluControl, illegalInstr
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// multicycle_control_alu_decoder
//   Combinational ALU operation decode.
//   op_class  : operation class from the main FSM
//   funct3    : instr[14:12]
//   funct7b5  : instr[30] (sub/sra select)
//   op5       : opcode[5], high for R-type; an I-type addi never subtracts
//   alu_op    : ALU operation code
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  alu_class_e  op_class,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output alu_op_e     alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (op_class)
            CLS_FUNCT: begin
                case (funct3)
                    3'b000: alu_op = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            CLS_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        alu_op = ALU_SUB;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle RV32I main controller (Moore FSM). Sequences fetch, decode,
//   execute, memory and writeback and drives the shared datapath.
//   Ports: clk, reset (synchronous, active-high); bus (multicycle_control_if
//   master modport); dbg_state (current FSM state).
//   RESET_VECTOR_SEL=1: the first cycle after reset loads the PC from the
//   reset vector (pcWrite, resultSrc=3) without a memory request; the fetch
//   itself starts on the following cycle.
//   Optional build macro ILLEGAL_TRAP_EN: unknown opcodes and R-type funct7
//   outside {0000000,0100000} enter TRAP, where every enable is held low and
//   illegalInstr stays high until reset. Without it unknown opcodes act as
//   NOPs and illegalInstr is tied low.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int RESET_VECTOR_SEL = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_if.master      bus,
    output logic [3:0]                dbg_state
);

    logic [3:0] state, next_state;
    logic       rv_pending;
    logic       rv_cycle;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_req, mem_write, reg_write, adr_src, branch_int;
    logic       fetch_go, pc_uncond, taken;
    logic [1:0] src_a, src_b, result_src;
    logic [2:0] imm_src;
    alu_class_e alu_class;
    alu_op_e    alu_op;

    assign opcode    = bus.instr[6:0];
    assign funct3    = bus.instr[14:12];
    assign dbg_state = state;
    assign rv_cycle  = (RESET_VECTOR_SEL != 0) && rv_pending && (state == S_FETCH);

`ifdef ILLEGAL_TRAP_EN
    logic funct7_ok;
    assign funct7_ok = (bus.instr[31:25] == 7'b0000000) || (bus.instr[31:25] == 7'b0100000);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            rv_pending <= 1'b1;
        end else begin
            state      <= next_state;
            rv_pending <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (!rv_cycle && bus.memReady) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
`ifdef ILLEGAL_TRAP_EN
                    OP_RTYPE:          next_state = funct7_ok ? S_EXECR : S_TRAP;
`else
                    OP_RTYPE:          next_state = S_EXECR;
`endif
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state = S_TRAP;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.memReady) next_state = S_MEMWB;
            S_MEMWRITE: if (bus.memReady) next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC: next_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     next_state = S_TRAP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        branch_int = 1'b0;
        fetch_go   = 1'b0;
        pc_uncond  = 1'b0;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        imm_src    = IMM_I;
        result_src = RES_ALUREG;
        alu_class  = CLS_ADD;
        case (state)
            S_FETCH: begin
                if (rv_cycle) begin
                    pc_uncond  = 1'b1;
                    result_src = RES_RSTVEC;
                end else begin
                    mem_req    = 1'b1;
                    fetch_go   = 1'b1;
                    src_b      = SRCB_FOUR;
                    result_src = RES_ALUOUT;
                end
            end
            S_DECODE: begin
                // Precompute the jump/branch target into the ALU result
                // register; jal needs the J immediate and jalr rs1+immI so
                // that their next state only has to load it and form the link.
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_IMM;
                imm_src = IMM_B;
                if (opcode == OP_JAL) begin
                    imm_src = IMM_J;
                end else if (opcode == OP_JALR) begin
                    src_a   = SRCA_RS1;
                    imm_src = IMM_I;
                end
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                imm_src = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                src_a     = SRCA_RS1;
                alu_class = CLS_FUNCT;
            end
            S_EXECI: begin
                src_a     = SRCA_RS1;
                src_b     = SRCB_IMM;
                alu_class = CLS_FUNCT;
            end
            S_ALUWB:  reg_write = 1'b1;
            S_BRANCH: begin
                src_a      = SRCA_RS1;
                alu_class  = CLS_BRANCH;
                branch_int = 1'b1;
            end
            S_JAL, S_JALR: begin
                // PC takes the precomputed target while the ALU forms oldPC+4
                // for the link written in ALUWB.
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                pc_uncond = 1'b1;
            end
            S_LUI: begin
                src_a   = SRCA_ZERO;
                src_b   = SRCB_IMM;
                imm_src = IMM_U;
            end
            S_AUIPC: begin
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_IMM;
                imm_src = IMM_U;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:         taken = bus.isZero;
            3'b001:         taken = !bus.isZero;
            3'b100, 3'b110: taken = bus.aluLsb;
            3'b101, 3'b111: taken = !bus.aluLsb;
            default:        taken = 1'b0;
        endcase
    end

    multicycle_control_alu_decoder u_alu_decoder (
        .op_class (alu_class),
        .funct3   (funct3),
        .funct7b5 (bus.instr[30]),
        .op5      (opcode[5]),
        .alu_op   (alu_op)
    );

    // Reset forces every output low in the same cycle, so an access that is
    // abandoned mid-instruction never produces a write.
    assign bus.memReq     = !reset && mem_req;
    assign bus.memWrite   = !reset && mem_write;
    assign bus.irWrite    = !reset && fetch_go && bus.memReady;
    assign bus.pcWrite    = !reset && (pc_uncond || (fetch_go && bus.memReady) || (branch_int && taken));
    assign bus.branch     = !reset && branch_int;
    assign bus.regWrite   = !reset && reg_write;
    assign bus.adrSrc     = !reset && adr_src;
    assign bus.aluSrcA    = reset ? 2'd0 : src_a;
    assign bus.aluSrcB    = reset ? 2'd0 : src_b;
    assign bus.immSrc     = reset ? 3'd0 : imm_src;
    assign bus.resultSrc  = reset ? 2'd0 : result_src;
    assign bus.aluControl = reset ? 4'd0 : alu_op;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegalInstr = !reset && (state == S_TRAP);
`else
    assign bus.illegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Expected per-cycle output
//   records come from an instruction-level model: each RV32I class expands to
//   its list of cycles, memory cycles repeat while memReady is low, and the
//   branch outcome is the real comparison of two operand values.
//   Record layout: {illegalInstr, memReq, memWrite, irWrite, pcWrite, branch,
//   regWrite, adrSrc, aluSrcA, aluSrcB, immSrc, resultSrc, aluControl}.
module tb_multicycle_control;

    localparam int W = 21;
    localparam logic [W-1:0] M_EN  = 21'h1FC000;
    localparam logic [W-1:0] M_ADR = 21'h002000;
    localparam logic [W-1:0] M_A   = 21'h001800;
    localparam logic [W-1:0] M_B   = 21'h000600;
    localparam logic [W-1:0] M_IMM = 21'h0001C0;
    localparam logic [W-1:0] M_RES = 21'h000030;
    localparam logic [W-1:0] M_ALU = 21'h00000F;
    localparam logic [W-1:0] M_ALL = 21'h1FFFFF;

    localparam logic [6:0] EN_ILL  = 7'b1000000;
    localparam logic [6:0] EN_MREQ = 7'b0100000;
    localparam logic [6:0] EN_MWR  = 7'b0010000;
    localparam logic [6:0] EN_IRW  = 7'b0001000;
    localparam logic [6:0] EN_PCW  = 7'b0000100;
    localparam logic [6:0] EN_BR   = 7'b0000010;
    localparam logic [6:0] EN_REGW = 7'b0000001;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] dbg_state;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(.RESET_VECTOR_SEL(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    logic [W-1:0] obs_q[$];
    logic [W-1:0] pend_e[$];
    logic [W-1:0] pend_m[$];
    bit           pend_w[$];
    int checks = 0;
    int passed = 0;

    function automatic logic [W-1:0] rec(input logic [6:0] en, input logic adr,
                                         input logic [1:0] a, input logic [1:0] b,
                                         input logic [2:0] imm, input logic [1:0] res,
                                         input logic [3:0] alu);
        return {en, adr, a, b, imm, res, alu};
    endfunction

    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'd0: return (is_r && f7b5) ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return f7b5 ? 4'd6 : 4'd7;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic [W-1:0] e, input logic [W-1:0] m, input bit w);
        pend_e.push_back(e);
        pend_m.push_back(m);
        pend_w.push_back(w);
    endtask

    task automatic build_expected(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [2:0] f3;
        logic       f7b5;
        logic [3:0] balu;
        logic [W-1:0] dec, dec_m, wb, wb_m;
        f3    = ins[14:12];
        f7b5  = ins[30];
        dec   = rec(7'd0, 1'b0, 2'd1, 2'd1, 3'd2, 2'd0, 4'd0);
        dec_m = M_EN | M_A | M_B | M_IMM | M_ALU;
        wb    = rec(EN_REGW, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0);
        wb_m  = M_EN | M_RES;
        push(rec(EN_MREQ | EN_IRW | EN_PCW, 1'b0, 2'd0, 2'd2, 3'd0, 2'd0, 4'd0),
             M_EN | M_ADR | M_A | M_B | M_ALU, 1'b1);
        case (ins[6:0])
            7'b0000011: begin
                push(dec, dec_m, 1'b0);
                push(rec(7'd0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, 4'd0), M_EN | M_A | M_B | M_IMM | M_ALU, 1'b0);
                push(rec(EN_MREQ, 1'b1, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0), M_EN | M_ADR, 1'b1);
                push(rec(EN_REGW, 1'b0, 2'd0, 2'd0, 3'd0, 2'd1, 4'd0), M_EN | M_RES, 1'b0);
            end
            7'b0100011: begin
                push(dec, dec_m, 1'b0);
                push(rec(7'd0, 1'b0, 2'd2, 2'd1, 3'd1, 2'd0, 4'd0), M_EN | M_A | M_B | M_IMM | M_ALU, 1'b0);
                push(rec(EN_MREQ | EN_MWR, 1'b1, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0), M_EN | M_ADR, 1'b1);
            end
            7'b0110011: begin
                push(dec, dec_m, 1'b0);
                push(rec(7'd0, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, exp_alu(f3, f7b5, 1'b1)), M_EN | M_A | M_B | M_ALU, 1'b0);
                push(wb, wb_m, 1'b0);
            end
            7'b0010011: begin
                push(dec, dec_m, 1'b0);
                push(rec(7'd0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, exp_alu(f3, f7b5, 1'b0)),
                     M_EN | M_A | M_B | M_IMM | M_ALU, 1'b0);
                push(wb, wb_m, 1'b0);
            end
            7'b1100011: begin
                push(dec, dec_m, 1'b0);
                balu = (f3[2:1] == 2'b10) ? 4'd3 : (f3[2:1] == 2'b11) ? 4'd4 : 4'd1;
                push(rec(br_taken(f3, a, b) ? (EN_BR | EN_PCW) : EN_BR, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, balu),
                     M_EN | M_A | M_B | M_RES | ((f3[2:1] == 2'b01) ? 21'h0 : M_ALU), 1'b0);
            end
            7'b1101111, 7'b1100111: begin
                push(dec, M_EN, 1'b0);
                push(rec(EN_PCW, 1'b0, 2'd1, 2'd2, 3'd0, 2'd0, 4'd0), M_EN | M_A | M_B | M_RES | M_ALU, 1'b0);
                push(wb, wb_m, 1'b0);
            end
            7'b0110111, 7'b0010111: begin
                push(dec, dec_m, 1'b0);
                push(rec(7'd0, 1'b0, ins[5] ? 2'd3 : 2'd1, 2'd1, 3'd4, 2'd0, 4'd0),
                     M_EN | M_A | M_B | M_IMM | M_ALU, 1'b0);
                push(wb, wb_m, 1'b0);
            end
            default: push(dec, M_EN, 1'b0);
        endcase
    endtask

    task automatic step(input logic rdy, input logic [W-1:0] e, input logic [W-1:0] m);
        bus.memReady = rdy;
        @(negedge clk);
        obs_q.push_back({bus.illegalInstr, bus.memReq, bus.memWrite, bus.irWrite, bus.pcWrite,
                         bus.branch, bus.regWrite, bus.adrSrc, bus.aluSrcA, bus.aluSrcB,
                         bus.immSrc, bus.resultSrc, bus.aluControl});
        exp_q.push_back(e);
        mask_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [W-1:0] e, m;
        logic [31:0]  diff;
        bit           w, lt;
        int           n;
        bus.instr = ins;
        diff = a - b;
        case (ins[14:12])
            3'd0, 3'd1: begin bus.isZero = (a == b); bus.aluLsb = diff[0]; end
            3'd4, 3'd5: begin lt = $signed(a) < $signed(b); bus.aluLsb = lt; bus.isZero = !lt; end
            3'd6, 3'd7: begin lt = a < b; bus.aluLsb = lt; bus.isZero = !lt; end
            default: begin bus.isZero = 1'($urandom_range(0, 1)); bus.aluLsb = 1'($urandom_range(0, 1)); end
        endcase
        build_expected(ins, a, b);
        while (pend_e.size() > 0) begin
            e = pend_e.pop_front();
            m = pend_m.pop_front();
            w = pend_w.pop_front();
            if (w) begin
                n = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                for (int k = 0; k < n; k++) step(1'b0, e & ~{EN_IRW | EN_PCW, 14'd0}, m);
                step(1'b1, e, m);
            end else begin
                step(1'($urandom_range(0, 1)), e, m);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  bad [4];
        int          cls;
        bad[0] = 7'h7F; bad[1] = 7'h00; bad[2] = 7'h0F; bad[3] = 7'h73;
        r   = $urandom();
        cls = $urandom_range(0, 9);
        case (cls)
            0: begin
                r[6:0]   = 7'b0110011;
                r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
`ifndef ILLEGAL_TRAP_EN
                if ($urandom_range(0, 5) == 0) r[31:25] = 7'($urandom());
`endif
            end
            1: r[6:0] = 7'b0000011;
            2: r[6:0] = 7'b0100011;
            3: r[6:0] = 7'b1100011;
            4: r[6:0] = 7'b1101111;
            5: r[6:0] = 7'b1100111;
            6: r[6:0] = 7'b0110111;
            7: r[6:0] = 7'b0010111;
`ifndef ILLEGAL_TRAP_EN
            9: r[6:0] = bad[$urandom_range(0, 3)];
`endif
            default: r[6:0] = 7'b0010011;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        logic [W-1:0] o, e, m;
        reset = 1'b1;
        bus.instr = 32'h002081B3;
        bus.isZero = 1'b1;
        bus.aluLsb = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 21'd0, M_ALL);
        reset = 1'b0;
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL reset cycle %0d: got %h expected %h mask %h", i, o, e, m);
            else passed++;
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] o, e, m;
        run_instr(32'h002081B3, 0, 0, 0);
        run_instr(32'h402081B3, 0, 0, 0);
        run_instr(32'h4020D1B3, 0, 0, 0);
        run_instr(32'h4010D193, 0, 0, 0);
        run_instr(32'h40008093, 0, 0, 0);
        run_instr(32'h0000A183, 0, 0, 3);
        run_instr(32'h0020A023, 0, 0, 1);
        run_instr(32'h00208063, 32'd5, 32'd5, 0);
        run_instr(32'h00209063, 32'd5, 32'd5, 0);
        run_instr(32'h0020E063, 32'd1, 32'd2, 0);
        run_instr(32'h0020C063, 32'hFFFF_FFFF, 32'd1, 0);
        run_instr(32'h008000EF, 0, 0, 0);
        run_instr(32'h000080E7, 0, 0, 0);
        run_instr(32'h123450B7, 0, 0, 0);
        run_instr(32'h00001097, 0, 0, 0);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL directed cycle %0d: got %h expected %h mask %h", i, o, e, m);
            else passed++;
        end
    endtask

    task automatic test_random_stream();
        logic [W-1:0] o, e, m;
        logic [31:0]  a, b;
        for (int n = 0; n < 200; n++) begin
            a = $urandom();
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (32'd1 << $urandom_range(0, 31));
                default: b = $urandom();
            endcase
            run_instr(rand_instr(), a, b, -1);
        end
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL random cycle %0d: got %h expected %h mask %h", i, o, e, m);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_store();
        logic [W-1:0] o, e, m;
        bus.instr = 32'h0020A023;
        step(1'b1, rec(EN_MREQ | EN_IRW | EN_PCW, 1'b0, 2'd0, 2'd2, 3'd0, 2'd0, 4'd0), M_EN);
        step(1'b1, rec(7'd0, 1'b0, 2'd1, 2'd1, 3'd2, 2'd0, 4'd0), M_EN);
        step(1'b1, rec(7'd0, 1'b0, 2'd2, 2'd1, 3'd1, 2'd0, 4'd0), M_EN | M_A | M_B | M_IMM);
        step(1'b0, rec(EN_MREQ | EN_MWR, 1'b1, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0), M_EN | M_ADR);
        reset = 1'b1;
        step(1'b1, 21'd0, M_ALL);
        reset = 1'b0;
        run_instr(32'h002081B3, 0, 0, 1);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL reset_mid_store cycle %0d: got %h expected %h mask %h", i, o, e, m);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] o, e, m;
`ifdef ILLEGAL_TRAP_EN
        bus.instr = 32'h0000007F;
        step(1'b1, rec(EN_MREQ | EN_IRW | EN_PCW, 1'b0, 2'd0, 2'd2, 3'd0, 2'd0, 4'd0), M_EN);
        step(1'b1, 21'd0, M_EN);
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), rec(EN_ILL, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0), M_EN);
        reset = 1'b1;
        step(1'b1, 21'd0, M_ALL);
        reset = 1'b0;
        bus.instr = 32'h022081B3;
        step(1'b1, rec(EN_MREQ | EN_IRW | EN_PCW, 1'b0, 2'd0, 2'd2, 3'd0, 2'd0, 4'd0), M_EN);
        step(1'b1, 21'd0, M_EN);
        for (int i = 0; i < 2; i++) step(1'b1, rec(EN_ILL, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0), M_EN);
        reset = 1'b1;
        step(1'b1, 21'd0, M_ALL);
        reset = 1'b0;
`else
        run_instr(32'h0000007F, 0, 0, 0);
        run_instr(32'h022081B3, 0, 0, 0);
`endif
        run_instr(32'h002081B3, 0, 0, 0);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL illegal cycle %0d: got %h expected %h mask %h", i, o, e, m);
            else passed++;
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.instr    = 32'd0;
        bus.isZero   = 1'b0;
        bus.aluLsb   = 1'b0;
        bus.memReady = 1'b0;
        test_reset();
        test_directed();
        test_random_stream();
        test_reset_mid_store();
        test_illegal();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
